boton_antirrebote_multi: RTL and testbench

Parametrised N-channel successor to the single-button debounce-plus-press-counter pair. Each channel does the following:
- synchronises the raw push-button input and normalises its polarity;
- debounces with a per-channel FSM;
- emits press, release and long-press strobes;
- keeps an independent clearable press counter.

The block sits between the board push-buttons and the control FSMs. It replaces the single debouncer and press tester with one instance.

---
 rtl/boton_antirrebote_multi.sv | 147 ++++++++++++++
 tb/tb_boton_antirrebote_multi.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boton_antirrebote_multi.sv
// N-channel push-button front end: 2-FF sync, per-channel debounce FSM, press/release/long strobes, press counter.
// Press/release strobes appear DEB_CYCLES+2 edges after the first sampling edge; no backpressure, all outputs registered.
module boton_antirrebote_multi #(
  parameter int N_BTN       = 4,
  parameter int DEB_CYCLES  = 50000,
  parameter int LONG_CYCLES = 5000000,
  parameter int CNT_W       = 4,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_BTN-1:0]       btn_in,
  input  logic [N_BTN-1:0]       cnt_clr,
  output logic [N_BTN-1:0]       btn_level,
  output logic [N_BTN-1:0]       btn_press,
  output logic [N_BTN-1:0]       btn_release,
  output logic [N_BTN-1:0]       btn_long,
  output logic [N_BTN*CNT_W-1:0] press_cnt
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  // The sample that moves the FSM out of IDLE/HELD is the first of the run,
  // so acceptance happens when deb_cnt has counted DEB_CYCLES-2 further samples.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [N_BTN-1:0]  RAW_IDLE  = {N_BTN{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } state_e;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] smp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign smp = sync2_q ^ RAW_IDLE;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_e            state_q;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0]  press_cnt_q;
    logic              level_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q     <= IDLE;
        deb_cnt_q   <= '0;
        hold_cnt_q  <= '0;
        press_cnt_q <= '0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;

        if (cnt_clr[i]) begin
          press_cnt_q <= '0;
        end

        // Hold time keeps running through release bounce; saturation limits btn_long to one pulse.
        if ((state_q == HELD || state_q == DEB_RELEASE) && hold_cnt_q != HOLD_MAX) begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (hold_cnt_q == HOLD_FIRE) begin
            long_q <= 1'b1;
          end
        end

        case (state_q)
          IDLE: begin
            if (smp[i]) begin
              state_q   <= DEB_PRESS;
              deb_cnt_q <= '0;
            end
          end
          DEB_PRESS: begin
            if (!smp[i]) begin
              state_q   <= IDLE;
              deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
              state_q     <= HELD;
              deb_cnt_q   <= '0;
              level_q     <= 1'b1;
              press_q     <= 1'b1;
              hold_cnt_q  <= '0;
              press_cnt_q <= (cnt_clr[i] ? '0 : press_cnt_q) + 1'b1;
            end else begin
              deb_cnt_q <= deb_cnt_q + 1'b1;
            end
          end
          HELD: begin
            if (!smp[i]) begin
              state_q   <= DEB_RELEASE;
              deb_cnt_q <= '0;
            end
          end
          DEB_RELEASE: begin
            if (smp[i]) begin
              state_q   <= HELD;
              deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
              state_q   <= IDLE;
              deb_cnt_q <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              deb_cnt_q <= deb_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]                  = level_q;
    assign btn_press[i]                  = press_q;
    assign btn_release[i]                = release_q;
    assign btn_long[i]                   = long_q;
    assign press_cnt[i*CNT_W +: CNT_W]   = press_cnt_q;
  end

endmodule

// File: tb/tb_boton_antirrebote_multi.sv
// Bench for boton_antirrebote_multi: 2 channels, DEB_CYCLES=4, LONG_CYCLES=20, active-low buttons.
// Expected strobe events are queued at stimulus time and matched by a negedge monitor.
module tb_boton_antirrebote_multi;

  localparam int DEB  = 4;
  localparam int LNG  = 20;
  localparam int LAT  = DEB + 2;

  logic       clk;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] cnt_clr;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;
  logic [7:0] press_cnt;

  boton_antirrebote_multi #(
    .N_BTN      (2),
    .DEB_CYCLES (DEB),
    .LONG_CYCLES(LNG),
    .CNT_W      (4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .cnt_clr    (cnt_clr),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .press_cnt  (press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lng;
    logic [1:0] lvl;
    logic [7:0] cnt;
  } ev_t;

  typedef struct {
    logic [1:0] mask;
    int         hold;
    logic [1:0] clr;
    logic       exp_long;
    logic [7:0] exp_cnt;
  } vec_t;

  ev_t        exp_q[$];
  int         cyc;
  int         checks;
  int         errors;
  logic [3:0] cnt_m [2];

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [7:0] cnt_pack();
    return {cnt_m[1], cnt_m[0]};
  endfunction

  function automatic void push_ev(input int cy, input logic [1:0] p, input logic [1:0] r,
                                  input logic [1:0] l, input logic [1:0] lv);
    ev_t e;
    e.cyc = cy;
    e.prs = p;
    e.rel = r;
    e.lng = l;
    e.lvl = lv;
    e.cnt = cnt_pack();
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin : mon
    ev_t e;
    if ((btn_press | btn_release | btn_long) != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'({btn_press, btn_release, btn_long}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_cycle", 32'(cyc), 32'(e.cyc));
        chk("ev_strobes", 32'({btn_press, btn_release, btn_long}), 32'({e.prs, e.rel, e.lng}));
        chk("ev_level", 32'(btn_level), 32'(e.lvl));
        chk("ev_cnt", 32'(press_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic press_ch(input logic [1:0] m, input int hold, input logic [1:0] clr, input logic lng);
    int c;
    @(negedge clk);
    c = cyc;
    btn_in = btn_in & ~m;
    for (int ch = 0; ch < 2; ch++) begin
      if (m[ch]) cnt_m[ch] = (clr[ch] ? 4'd0 : cnt_m[ch]) + 4'd1;
    end
    push_ev(c + LAT, m, 2'b00, 2'b00, m);
    if (lng) push_ev(c + LAT + LNG, 2'b00, 2'b00, m, m);
    push_ev(c + hold + LAT, 2'b00, m, 2'b00, 2'b00);
    // Clear lines up with the edge that accepts the press.
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      cnt_clr = (k == LAT - 1) ? clr : 2'b00;
    end
    btn_in = btn_in | m;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    int   c;

    vecs[0] = '{2'b01, 12, 2'b00, 1'b0, 8'h01};
    vecs[1] = '{2'b01, 40, 2'b00, 1'b1, 8'h02};
    vecs[2] = '{2'b01, 10, 2'b00, 1'b0, 8'h03};
    vecs[3] = '{2'b11,  8, 2'b00, 1'b0, 8'h14};
    vecs[4] = '{2'b01,  8, 2'b01, 1'b0, 8'h11};
    vecs[5] = '{2'b10,  8, 2'b00, 1'b0, 8'h21};
    vecs[6] = '{2'b10, 24, 2'b10, 1'b1, 8'h11};

    cyc     = 0;
    checks  = 0;
    errors  = 0;
    cnt_m[0] = 4'd0;
    cnt_m[1] = 4'd0;
    btn_in  = 2'b11;
    cnt_clr = 2'b00;
    rst     = 1'b1;
    #2 rst  = 1'b0;
    #2;
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_strobes", 32'({btn_press, btn_release, btn_long}), 32'd0);
    chk("rst_cnt", 32'(press_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      press_ch(vecs[v].mask, vecs[v].hold, vecs[v].clr, vecs[v].exp_long);
      chk("vec_pending", 32'(exp_q.size()), 32'd0);
      chk("vec_cnt", 32'(press_cnt), 32'(vecs[v].exp_cnt));
      chk("vec_level", 32'(btn_level), 32'd0);
    end

    // Press bounce: 2-cycle runs never complete debounce.
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      btn_in[0] = 1'b0;
      repeat (2) @(negedge clk);
      btn_in[0] = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("bounce_level", 32'(btn_level), 32'd0);
    chk("bounce_cnt", 32'(press_cnt), 32'h11);

    // Release bounce while held: one press, one release, no long.
    @(negedge clk);
    c = cyc;
    btn_in[0] = 1'b0;
    cnt_m[0] = cnt_m[0] + 4'd1;
    push_ev(c + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
    push_ev(c + 16 + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
    repeat (10) @(negedge clk);
    btn_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("relbounce_level", 32'(btn_level), 32'h1);
    btn_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("relbounce_pending", 32'(exp_q.size()), 32'd0);
    chk("relbounce_cnt", 32'(press_cnt), 32'h12);

    // Clears alone, one channel at a time.
    cnt_clr = 2'b10;
    @(negedge clk);
    cnt_clr = 2'b00;
    cnt_m[1] = 4'd0;
    chk("clr1_only", 32'(press_cnt), 32'h02);
    cnt_clr = 2'b01;
    @(negedge clk);
    cnt_clr = 2'b00;
    cnt_m[0] = 4'd0;
    chk("clr0_only", 32'(press_cnt), 32'h00);

    for (int n = 0; n < 17; n++) begin
      press_ch(2'b01, 8, 2'b00, 1'b0);
    end
    chk("wrap_pending", 32'(exp_q.size()), 32'd0);
    chk("wrap_cnt", 32'(press_cnt), 32'h01);

    // Reset while held, button kept down across release.
    @(negedge clk);
    c = cyc;
    btn_in[0] = 1'b0;
    cnt_m[0] = cnt_m[0] + 4'd1;
    push_ev(c + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_level", 32'(btn_level), 32'd0);
    chk("midrst_strobes", 32'({btn_press, btn_release, btn_long}), 32'd0);
    chk("midrst_cnt", 32'(press_cnt), 32'd0);
    cnt_m[0] = 4'd0;
    cnt_m[1] = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    c = cyc;
    cnt_m[0] = 4'd1;
    push_ev(c + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
    repeat (10) @(negedge clk);
    chk("postrst_cnt", 32'(press_cnt), 32'h01);
    chk("postrst_level", 32'(btn_level), 32'h1);
    c = cyc;
    btn_in[0] = 1'b1;
    push_ev(c + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
    repeat (10) @(negedge clk);

    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
